// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types and limits for the serial pattern detector
package seq_detect_pkg;

    localparam int MAX_LEN_LIMIT = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// rtl/seq_detect_param_sat_counter.sv - saturating event counter with registered full flag
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // The flag tracks the next count so it changes on the same edge as cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= &cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - run-time programmable serial pattern detector with Mealy match output
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat,
    output logic               cfg_err,
    output logic               active
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic               err_q, err_d;

    logic               cfg_ok;
    logic               run_bit;
    logic               fill_ok;
    logic               match;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;

    assign cfg_ok  = (pat_len != '0) && (pat_len <= MAX_LEN_L);
    assign run_bit = (state_q == RUN) && in_valid && !cfg_load;
    assign cand    = {hist_q[MAX_LEN-2:0], in_bit};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    // Enough bits must have arrived since the last restart to fill the window.
    assign fill_ok = ({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q};
    assign match   = run_bit && fill_ok && ((cand & mask) == (pat_q & mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = cfg_ok ? RUN : IDLE;
        end
    end

    always_comb begin
        active = (state_q == RUN);
        out    = match;
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        err_d  = err_q;
        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
            if (cfg_ok) begin
                pat_d = pattern;
                len_d = pat_len;
                ovl_d = overlap;
                err_d = 1'b0;
            end else begin
                pat_d = '0;
                len_d = '0;
                ovl_d = 1'b0;
                err_d = 1'b1;
            end
        end else if (run_bit) begin
            hist_d = cand;
            if (match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != MAX_LEN_L) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            err_q  <= err_d;
        end
    end

    assign cfg_err = err_q;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cfg_load && cfg_ok),
        .inc  (match),
        .cnt  (match_cnt),
        .sat  (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param against a bit-queue model
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [3:0]         pat_len = '0;
    logic               overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;
    logic               cfg_err;
    logic               active;

    seq_detect_param #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_load (cfg_load),
        .pattern  (pattern),
        .pat_len  (pat_len),
        .overlap  (overlap),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .out      (out),
        .match_cnt(match_cnt),
        .cnt_sat  (cnt_sat),
        .cfg_err  (cfg_err),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit out;
        int cnt;
        bit sat;
        bit act;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: bits received since the last restart, newest at the back.
    bit             m_run = 0;
    bit             m_err = 0;
    bit [MAX_LEN-1:0] m_pat = '0;
    int             m_len = 0;
    bit             m_ovl = 0;
    int             m_cnt = 0;
    bit             m_hist[$];

    function automatic void check(string name, int act, int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    endfunction

    function automatic bit model_match(bit b);
        int sz;
        bit got;
        if (!m_run) return 0;
        sz = m_hist.size();
        if (sz + 1 < m_len) return 0;
        for (int k = 0; k < m_len; k++) begin
            got = (k == 0) ? b : m_hist[sz - k];
            if (got != m_pat[k]) return 0;
        end
        return 1;
    endfunction

    function automatic void model_reset();
        m_run = 0; m_err = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_cnt = 0;
        m_hist.delete();
    endfunction

    task automatic step(bit ld, bit [MAX_LEN-1:0] p, int l, bit o, bit v, bit b);
        exp_t e;
        bit   hit;
        @(posedge clk);
        #1;
        cfg_load = ld; pattern = p; pat_len = 4'(l); overlap = o;
        in_valid = v; in_bit = b;
        hit = (!ld && v) ? model_match(b) : 1'b0;
        e.out = hit; e.cnt = m_cnt; e.sat = (m_cnt == CNT_MAX);
        e.act = m_run; e.err = m_err;
        exp_q.push_back(e);
        if (ld) begin
            m_hist.delete();
            if (l >= 1 && l <= MAX_LEN) begin
                m_run = 1; m_err = 0; m_pat = p; m_len = l; m_ovl = o; m_cnt = 0;
            end else begin
                m_run = 0; m_err = 1; m_pat = '0; m_len = 0; m_ovl = 0;
            end
        end else if (v && m_run) begin
            m_hist.push_back(b);
            if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
            if (hit) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_ovl) m_hist.delete();
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic bits(bit [15:0] seq, int n, bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            step(0, '0, 0, 0, 1, seq[i]);
            if (gaps) idle(1);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out", out, e.out);
                check("match_cnt", match_cnt, e.cnt);
                check("cnt_sat", cnt_sat, e.sat);
                check("active", active, e.act);
                check("cfg_err", cfg_err, e.err);
            end
        end
    end

    initial begin
        int len;
        #2;
        check("reset_out", out, 0);
        check("reset_cnt", match_cnt, 0);
        check("reset_sat", cnt_sat, 0);
        check("reset_active", active, 0);
        check("reset_err", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 8'b101, 3, 1, 0, 0);
        bits(16'b10101, 5, 0);
        idle(2);
        step(1, 8'b101, 3, 0, 0, 0);
        bits(16'b10101, 5, 0);
        idle(2);
        step(1, 8'b1101, 4, 1, 0, 0);
        bits(16'b1101, 4, 1);
        idle(1);
        step(1, 8'b1, 1, 0, 0, 0);
        bits(16'b11111, 5, 0);
        idle(1);
        step(1, 8'b1, 1, 1, 1, 1);
        bits(16'b0110, 4, 0);
        step(1, 8'hA5, MAX_LEN, 1, 0, 0);
        bits(16'hA5A5, 16, 0);
        idle(1);

        step(1, 8'b101, 0, 1, 0, 0);
        bits(16'b1010110101, 10, 0);
        step(1, 8'b101, MAX_LEN + 1, 1, 0, 0);
        bits(16'b1010110101, 10, 0);
        step(1, 8'b101, 3, 1, 0, 0);
        bits(16'b101, 3, 0);
        idle(1);

        step(1, 8'b101, 3, 1, 0, 0);
        bits(16'b1010, 4, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        cfg_load = 0; in_valid = 1; in_bit = 1;
        #1;
        check("rst_pre_out", out, 1);
        check("rst_pre_cnt", match_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_out", out, 0);
        check("rst_async_cnt", match_cnt, 0);
        check("rst_async_active", active, 0);
        check("rst_async_sat", cnt_sat, 0);
        in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 8'b101, 3, 1, 0, 0);
        bits(16'b1, 1, 0);
        idle(1);

        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 7) == 0)
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 15);
            else if ($urandom_range(0, 3) == 0)
                len = $urandom_range(1, MAX_LEN);
            else
                len = $urandom_range(1, 4);
            step(1, MAX_LEN'($urandom), len, 1'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < $urandom_range(20, 40); i++)
                step(0, MAX_LEN'($urandom), 0, 0, ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
